csr_commit: RTL and testbench

Commit-side CSR sequencer sitting directly upstream of the CSR register file, between the memory stage and the CSR regs/trap logic. Accepts one CSR/system instruction at a time via valid/ready and performs the CSRRW/CSRRS/CSRRC read-modify-write (including immediate forms) itself. Raises ecall, instruction-misaligned and mret strobes for exactly one cycle. For traps, mret and serializing CSR writes, issues a pipeline flush and redirect, then holds off new work for a fixed drain window.

---
 rtl/csr_pkg.sv | 40 ++++
 rtl/csr_alu.sv | 46 ++++
 rtl/csr_commit.sv | 147 ++++++++++++++
 tb/tb_csr_commit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared types and constants for the CSR commit path.
package csr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_REDIRECT,
        ST_DRAIN
    } csr_commit_state_t;

    localparam logic [2:0] CSR_OP_RW  = 3'b001;
    localparam logic [2:0] CSR_OP_RS  = 3'b010;
    localparam logic [2:0] CSR_OP_RC  = 3'b011;
    localparam logic [2:0] CSR_OP_RWI = 3'b101;
    localparam logic [2:0] CSR_OP_RSI = 3'b110;
    localparam logic [2:0] CSR_OP_RCI = 3'b111;

    localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_SATP    = 12'h180;

    typedef struct packed {
        logic [63:0] pc;
        logic [2:0]  funct3;
        logic [11:0] csr_addr;
        logic [4:0]  rs1_idx;
        logic [63:0] rs1_val;
        logic [4:0]  zimm;
        logic        is_csr;
        logic        is_ecall;
        logic        is_mret;
        logic        misalign;
    } csr_req_t;

    // Writes to these CSRs change translation/privilege state for younger instructions.
    function automatic logic is_serializing(input logic [11:0] addr);
        return (addr == CSR_MSTATUS) || (addr == CSR_SATP);
    endfunction

endpackage

// File: rtl/csr_alu.sv
// Combinational CSR read-modify-write: computes the new CSR value and whether it is written.
module csr_alu
    import csr_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [63:0] rdata,
    input  logic [63:0] rs1_val,
    input  logic [4:0]  rs1_idx,
    input  logic [4:0]  zimm,
    output logic [63:0] wdata,
    output logic        do_write,
    output logic        legal
);

    logic [63:0] w_operand;
    logic        w_src_nonzero;

    assign w_operand     = funct3[2] ? {59'd0, zimm} : rs1_val;
    assign w_src_nonzero = funct3[2] ? (zimm != 5'd0) : (rs1_idx != 5'd0);

    // Set/clear with a zero source is a pure read and must not write.
    always_comb begin
        wdata    = '0;
        do_write = 1'b0;
        legal    = 1'b0;
        case (funct3[1:0])
            2'b01: begin
                wdata    = w_operand;
                do_write = 1'b1;
                legal    = 1'b1;
            end
            2'b10: begin
                wdata    = rdata | w_operand;
                do_write = w_src_nonzero;
                legal    = 1'b1;
            end
            2'b11: begin
                wdata    = rdata & ~w_operand;
                do_write = w_src_nonzero;
                legal    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/csr_commit.sv
// Commit-side CSR sequencer: one CSR/system instruction at a time, RMW, trap strobes, flush/redirect and drain.
module csr_commit
    import csr_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_pc,
    input  logic [2:0]  in_funct3,
    input  logic [11:0] in_csr_addr,
    input  logic [4:0]  in_rs1_idx,
    input  logic [63:0] in_rs1_val,
    input  logic [4:0]  in_zimm,
    input  logic        in_is_csr,
    input  logic        in_is_ecall,
    input  logic        in_is_mret,
    input  logic        in_misalign,
    input  logic [63:0] csr_rdata,
    input  logic [63:0] next_pc,
    output logic [11:0] csr_addr_read,
    output logic [11:0] csr_addr_write,
    output logic [63:0] csr_wdata,
    output logic        csr_we,
    output logic        isCSRRC,
    output logic        exception,
    output logic        isEcall,
    output logic        isInstrMisalign,
    output logic        isMRET,
    output logic [63:0] pc,
    output logic        mcycle_inc,
    output logic        wb_valid,
    output logic [63:0] wb_data,
    output logic        flush,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    csr_commit_state_t r_state;
    csr_req_t          r_hold;
    logic [CNT_W-1:0]  r_drain_cnt;
    logic [63:0]       r_redirect_pc;
    logic [63:0]       r_wb_data;

    logic        w_on, w_exec;
    logic        w_mis, w_ecall, w_mret, w_csr, w_trap;
    logic [63:0] w_alu_wdata;
    logic        w_alu_write, w_alu_legal;
    logic        w_we, w_wbv, w_serialize;

    csr_alu u_alu (
        .funct3   (r_hold.funct3),
        .rdata    (csr_rdata),
        .rs1_val  (r_hold.rs1_val),
        .rs1_idx  (r_hold.rs1_idx),
        .zimm     (r_hold.zimm),
        .wdata    (w_alu_wdata),
        .do_write (w_alu_write),
        .legal    (w_alu_legal)
    );

    // One event per instruction: misalign > ecall > mret > csr.
    assign w_on        = !reset;
    assign w_exec      = (r_state == ST_EXEC);
    assign w_mis       = w_exec && r_hold.misalign;
    assign w_ecall     = w_exec && !r_hold.misalign && r_hold.is_ecall;
    assign w_mret      = w_exec && !r_hold.misalign && !r_hold.is_ecall && r_hold.is_mret;
    assign w_csr       = w_exec && !r_hold.misalign && !r_hold.is_ecall && !r_hold.is_mret
                         && r_hold.is_csr;
    assign w_trap      = w_mis || w_ecall || w_mret;
    assign w_wbv       = w_csr && w_alu_legal;
    assign w_we        = w_wbv && w_alu_write;
    assign w_serialize = w_we && is_serializing(r_hold.csr_addr);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_hold        <= '0;
            r_drain_cnt   <= '0;
            r_redirect_pc <= '0;
            r_wb_data     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_hold <= '{pc: in_pc, funct3: in_funct3, csr_addr: in_csr_addr,
                                    rs1_idx: in_rs1_idx, rs1_val: in_rs1_val, zimm: in_zimm,
                                    is_csr: in_is_csr, is_ecall: in_is_ecall,
                                    is_mret: in_is_mret, misalign: in_misalign};
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (w_wbv)
                        r_wb_data <= csr_rdata;
                    if (w_trap) begin
                        r_redirect_pc <= next_pc;
                        r_state       <= ST_REDIRECT;
                    end else if (w_serialize) begin
                        r_redirect_pc <= r_hold.pc + 64'd4;
                        r_state       <= ST_REDIRECT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_REDIRECT: begin
                    r_drain_cnt <= '0;
                    r_state     <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == DRAIN_LAST) begin
                        r_drain_cnt <= '0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Outputs are forced low while reset is held, not just after the reset edge.
    assign in_ready        = w_on && (r_state == ST_IDLE);
    assign csr_addr_read   = w_on ? r_hold.csr_addr : 12'd0;
    assign csr_addr_write  = w_on ? r_hold.csr_addr : 12'd0;
    assign csr_wdata       = w_on ? w_alu_wdata : 64'd0;
    assign csr_we          = w_on && w_we;
    assign isCSRRC         = 1'b0;
    assign exception       = w_on && (w_mis || w_ecall);
    assign isEcall         = w_on && w_ecall;
    assign isInstrMisalign = w_on && w_mis;
    assign isMRET          = w_on && w_mret;
    assign pc              = w_on ? r_hold.pc : 64'd0;
    assign mcycle_inc      = w_on && !(w_we && (r_hold.csr_addr == CSR_MCYCLE));
    assign wb_valid        = w_on && w_wbv;
    assign wb_data         = !w_on ? 64'd0 : (w_wbv ? csr_rdata : r_wb_data);
    assign flush           = w_on && (r_state == ST_REDIRECT);
    assign redirect_valid  = w_on && (r_state == ST_REDIRECT);
    assign redirect_pc     = w_on ? r_redirect_pc : 64'd0;

endmodule

// File: tb/tb_csr_commit.sv
// Randomized scoreboard bench for csr_commit against a transaction-level reference model.
module tb_csr_commit;
    import csr_pkg::*;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [63:0] in_pc, in_rs1_val, csr_rdata, next_pc;
    logic [2:0]  in_funct3;
    logic [11:0] in_csr_addr;
    logic [4:0]  in_rs1_idx, in_zimm;
    logic        in_is_csr, in_is_ecall, in_is_mret, in_misalign;
    logic [11:0] csr_addr_read, csr_addr_write;
    logic [63:0] csr_wdata, pc, wb_data, redirect_pc;
    logic        csr_we, isCSRRC, exception, isEcall, isInstrMisalign, isMRET;
    logic        mcycle_inc, wb_valid, flush, redirect_valid;

    csr_commit #(.DRAIN_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_funct3(in_funct3), .in_csr_addr(in_csr_addr),
        .in_rs1_idx(in_rs1_idx), .in_rs1_val(in_rs1_val), .in_zimm(in_zimm),
        .in_is_csr(in_is_csr), .in_is_ecall(in_is_ecall), .in_is_mret(in_is_mret),
        .in_misalign(in_misalign), .csr_rdata(csr_rdata), .next_pc(next_pc),
        .csr_addr_read(csr_addr_read), .csr_addr_write(csr_addr_write),
        .csr_wdata(csr_wdata), .csr_we(csr_we), .isCSRRC(isCSRRC),
        .exception(exception), .isEcall(isEcall), .isInstrMisalign(isInstrMisalign),
        .isMRET(isMRET), .pc(pc), .mcycle_inc(mcycle_inc), .wb_valid(wb_valid),
        .wb_data(wb_data), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc, rs1_val, rdata, npc;
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [4:0]  rs1_idx, zimm;
        logic        is_csr, ecall, mret, mis;
    } txn_t;

    typedef struct {
        logic        mis, ecall, mret, exc, we, wbv, redir, mcyc;
        logic [63:0] wdata, wbd, pc, rpc;
        logic [11:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference: spec rules applied to a whole instruction at once.
    function automatic exp_t model(input txn_t t);
        exp_t        e;
        logic [63:0] opnd;
        logic        src_nz;
        e = '{default: '0};
        e.pc = t.pc; e.addr = t.addr; e.mcyc = 1'b1;
        opnd   = t.f3[2] ? {59'd0, t.zimm} : t.rs1_val;
        src_nz = t.f3[2] ? (t.zimm != 0) : (t.rs1_idx != 0);
        if (t.mis) begin
            e.mis = 1; e.exc = 1; e.redir = 1; e.rpc = t.npc;
        end else if (t.ecall) begin
            e.ecall = 1; e.exc = 1; e.redir = 1; e.rpc = t.npc;
        end else if (t.mret) begin
            e.mret = 1; e.redir = 1; e.rpc = t.npc;
        end else if (t.is_csr && t.f3 != 3'b000 && t.f3 != 3'b100) begin
            e.wbv = 1; e.wbd = t.rdata;
            if (t.f3 == CSR_OP_RW || t.f3 == CSR_OP_RWI) begin
                e.wdata = opnd; e.we = 1;
            end else if (t.f3 == CSR_OP_RS || t.f3 == CSR_OP_RSI) begin
                e.wdata = t.rdata | opnd; e.we = src_nz;
            end else begin
                e.wdata = t.rdata & ~opnd; e.we = src_nz;
            end
            if (e.we && (t.addr == 12'h300 || t.addr == 12'h180)) begin
                e.redir = 1; e.rpc = t.pc + 64'd4;
            end
            if (e.we && t.addr == 12'hB00) e.mcyc = 0;
        end
        return e;
    endfunction

    function automatic txn_t blank();
        txn_t t;
        t = '{default: '0};
        t.is_csr = 1;
        return t;
    endfunction

    task automatic issue(input txn_t t);
        int k;
        @(posedge clk); #1;
        in_pc = t.pc; in_funct3 = t.f3; in_csr_addr = t.addr; in_rs1_idx = t.rs1_idx;
        in_rs1_val = t.rs1_val; in_zimm = t.zimm; in_is_csr = t.is_csr;
        in_is_ecall = t.ecall; in_is_mret = t.mret; in_misalign = t.mis;
        csr_rdata = t.rdata; next_pc = t.npc;
        in_valid = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!in_ready && k < 50);
        if (in_ready) exp_q.push_back(model(t));
        else chk("handshake_timeout", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Monitor: tracks the expected cycle phase of the last accepted instruction.
    localparam int M_IDLE = 0, M_EXEC = 1, M_REDIR = 2, M_DRAIN = 3, M_READY = 4;
    int   mode = M_READY;
    int   dcnt = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (reset) begin
            chk("reset_outputs",
                {in_ready, flush, redirect_valid, csr_we, isCSRRC, exception, isEcall,
                 isMRET, isInstrMisalign, wb_valid, mcycle_inc} == 11'd0 ? 64'd0 : 64'd1, 64'd0);
            chk("reset_pc", pc | redirect_pc | wb_data | csr_wdata | {52'd0, csr_addr_read}, 64'd0);
            mode = M_READY;
        end else begin
            case (mode)
                M_IDLE, M_READY: begin
                    if (mode == M_READY) begin
                        chk("ready_after_op", {63'd0, in_ready}, 64'd1);
                        chk("idle_quiet", {58'd0, flush, csr_we, exception, isMRET, wb_valid,
                                           !mcycle_inc}, 64'd0);
                    end
                    mode = (in_valid && in_ready) ? M_EXEC : M_IDLE;
                end
                M_EXEC: begin
                    if (exp_q.size() == 0) begin
                        chk("exec_without_expect", 64'd1, 64'd0);
                        mode = M_IDLE;
                    end else begin
                        cur = exp_q.pop_front();
                        chk("isInstrMisalign", {63'd0, isInstrMisalign}, {63'd0, cur.mis});
                        chk("isEcall", {63'd0, isEcall}, {63'd0, cur.ecall});
                        chk("isMRET", {63'd0, isMRET}, {63'd0, cur.mret});
                        chk("exception", {63'd0, exception}, {63'd0, cur.exc});
                        chk("csr_we", {63'd0, csr_we}, {63'd0, cur.we});
                        if (cur.we) chk("csr_wdata", csr_wdata, cur.wdata);
                        chk("wb_valid", {63'd0, wb_valid}, {63'd0, cur.wbv});
                        if (cur.wbv) chk("wb_data", wb_data, cur.wbd);
                        chk("pc", pc, cur.pc);
                        chk("csr_addr_read", {52'd0, csr_addr_read}, {52'd0, cur.addr});
                        chk("csr_addr_write", {52'd0, csr_addr_write}, {52'd0, cur.addr});
                        chk("mcycle_inc", {63'd0, mcycle_inc}, {63'd0, cur.mcyc});
                        chk("exec_ready_low", {62'd0, in_ready, flush}, 64'd0);
                        mode = cur.redir ? M_REDIR : M_READY;
                    end
                end
                M_REDIR: begin
                    chk("flush", {63'd0, flush}, 64'd1);
                    chk("redirect_valid", {63'd0, redirect_valid}, 64'd1);
                    chk("redirect_pc", redirect_pc, cur.rpc);
                    chk("redir_ready_low", {62'd0, in_ready, csr_we}, 64'd0);
                    dcnt = 0;
                    mode = M_DRAIN;
                end
                M_DRAIN: begin
                    chk("drain_ready_low", {61'd0, in_ready, flush, redirect_valid}, 64'd0);
                    dcnt++;
                    if (dcnt == D) mode = M_READY;
                end
                default: mode = M_IDLE;
            endcase
        end
    end

    txn_t t;

    initial begin
        reset = 1'b1; in_valid = 1'b0;
        in_pc = '0; in_funct3 = '0; in_csr_addr = '0; in_rs1_idx = '0; in_rs1_val = '0;
        in_zimm = '0; in_is_csr = 0; in_is_ecall = 0; in_is_mret = 0; in_misalign = 0;
        csr_rdata = '0; next_pc = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        t = blank(); t.f3 = CSR_OP_RW; t.addr = 12'h305; t.rs1_idx = 5'd3;
        t.rs1_val = 64'h80000100; t.pc = 64'h80000000;
        issue(t);
        t = blank(); t.f3 = CSR_OP_RS; t.addr = CSR_MSTATUS; t.rs1_idx = 5'd0;
        t.rs1_val = 64'hFF; t.rdata = 64'h1800;
        issue(t);
        t = blank(); t.f3 = CSR_OP_RCI; t.addr = CSR_MSTATUS; t.zimm = 5'd8;
        t.rdata = 64'h1888; t.pc = 64'h80000004;
        issue(t);
        t = blank(); t.is_csr = 0; t.ecall = 1; t.pc = 64'h80000010; t.npc = 64'h80000200;
        issue(t);
        t = blank(); t.is_csr = 0; t.ecall = 1; t.mis = 1; t.pc = 64'h80000020;
        t.npc = 64'h80000100;
        issue(t);
        t = blank(); t.is_csr = 0; t.mret = 1; t.npc = 64'h80000040;
        issue(t);
        t = blank(); t.f3 = CSR_OP_RWI; t.addr = CSR_MCYCLE; t.zimm = 5'd0;
        issue(t);
        t = blank(); t.f3 = 3'b100; t.addr = CSR_SATP; t.rs1_idx = 5'd1;
        issue(t);

        // Reset during drain aborts cleanly.
        t = blank(); t.f3 = CSR_OP_RW; t.addr = CSR_SATP; t.rs1_idx = 5'd2;
        t.rs1_val = 64'h8000_0000_0000_1234; t.pc = 64'h80000050;
        issue(t);
        @(posedge clk); @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
        t = blank(); t.f3 = CSR_OP_RW; t.addr = 12'h340; t.rs1_idx = 5'd5;
        t.rs1_val = 64'hDEADBEEF; t.rdata = 64'h55;
        issue(t);

        for (int i = 0; i < 300; i++) begin
            t.f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0: t.addr = CSR_MSTATUS;
                1: t.addr = CSR_SATP;
                2: t.addr = CSR_MCYCLE;
                3: t.addr = 12'h305;
                default: t.addr = 12'($urandom);
            endcase
            t.rs1_idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            t.zimm    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            t.rs1_val = {$urandom, $urandom};
            t.rdata   = {$urandom, $urandom};
            t.npc     = {$urandom, $urandom};
            t.pc      = {$urandom, $urandom};
            t.is_csr  = ($urandom_range(0, 9) != 0);
            t.mis     = ($urandom_range(0, 9) == 0);
            t.ecall   = ($urandom_range(0, 9) == 0);
            t.mret    = ($urandom_range(0, 9) == 0);
            issue(t);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (10) @(posedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
